divider_check_mult: RTL and testbench
=====================================

Name: divider_check_mult

Overview:
- Sequential multiply-add, the inverse of the divider: computes dividend = quotient * divisor + remainder.
- Sits beside the divider in the datapath.
- Used to round-trip-check divider results and to rebuild scaled values from quotient/remainder pairs.
- Radix-2 shift-add, one divisor bit per cycle, start/busy/done handshake.

Parameters:
DIVIDEND_WIDTH, 32, width of quotient input and dividend output
DIVISOR_WIDTH, 16, width of divisor and remainder inputs; also the iteration count

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
quotient  input  DIVIDEND_WIDTH  multiplicand; latched on accepted start
divisor  input  DIVISOR_WIDTH  multiplier; latched on accepted start
remainder  input  DIVISOR_WIDTH  addend, zero-extended; latched on accepted start
dividend  output  DIVIDEND_WIDTH  low DIVIDEND_WIDTH bits of the result
overflow  output  1  result does not fit in DIVIDEND_WIDTH bits
busy  output  1  high in CALC and DONE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; dividend=0, overflow=0, busy=0, done=0; internal accumulator, operands and counter cleared.
- Reset wins over every other event, including mid-operation. The in-flight operation is discarded and no done is produced.
- Accumulator width ACC_W = DIVIDEND_WIDTH+DIVISOR_WIDTH, all unsigned. Maximum value (2^32-1)(2^16-1)+(2^16-1) = 2^48-2^32, so the accumulator never wraps.
- IDLE, start=1 at edge N:
  - acc <= zero-extended remainder; mcand <= quotient (ACC_W wide); mplier <= divisor; cnt <= 0.
  - state <= CALC, busy <= 1.
- CALC, each edge:
  - if mplier[0]=1 then acc <= acc + mcand;
  - mcand <<= 1; mplier >>= 1; cnt++.
- The final iteration is the edge where cnt == DIVISOR_WIDTH-1. At that same edge, using the combinational next-acc value:
  - dividend <= next_acc[DIVIDEND_WIDTH-1:0];
  - overflow <= |next_acc[ACC_W-1:DIVIDEND_WIDTH];
  - done <= 1; state <= DONE.
- DONE, next edge: done <= 0, busy <= 0, state <= IDLE.
- Latency: start sampled at edge N gives done=1 in the cycle after edge N+DIVISOR_WIDTH (N+16 by default). busy is high from edge N to edge N+DIVISOR_WIDTH+1. Next start is accepted at edge N+DIVISOR_WIDTH+1 at the earliest.
- start while busy (CALC or DONE) is ignored. Operands presented then have no effect.
- dividend and overflow hold their values between completions. They change only at a completion edge or on reset.
- divisor=0 gives dividend=remainder, overflow=0; full latency still applies unless the optional feature is enabled.
- Operand inputs are don't-care except at the accepted start edge.

Optional Feature:
- Macro DIVIDER_CHECK_MULT_EARLY_TERM_EN.
- Defined: a CALC edge is also final when the shifted mplier becomes zero. Iterations = max(1, bit index of divisor MSB + 1), so divisor=0 takes 1 iteration and divisor=1 takes 1 iteration. Results are identical to the non-feature build; only latency changes. done stays a one-cycle pulse, followed by DONE->IDLE.
- Undefined: always exactly DIVISOR_WIDTH iterations; early-termination logic absent.

Test Plan:
- Basic: quotient=1000, divisor=7, remainder=5, start at edge N -> dividend=7005, overflow=0, done high for exactly one cycle after edge N+16, busy low after edge N+17.
- Max operands: quotient=0xFFFFFFFF, divisor=0xFFFF, remainder=0xFFFF -> dividend=0x00000000, overflow=1.
- Overflow boundary:
  - 0x00010001*0xFFFF+0 -> dividend=0xFFFFFFFF, overflow=0.
  - Same operands with remainder=1 -> dividend=0x00000000, overflow=1.
- Handshake/reset:
  - start pulsed again at edge N+5 with different operands -> ignored; first result returned.
  - reset at edge N+8 -> all outputs 0, no done.
  - New start after reset -> correct result.
- Round trip: dividend=100000, divisor=300 -> divider gives quotient=333, remainder=100; feeding these into this block gives dividend=100000, overflow=0.
  - With DIVIDER_CHECK_MULT_EARLY_TERM_EN: divisor=0 and remainder=9 -> dividend=9 with done after edge N+1.
  - Same build: divisor=0x0005 -> done after edge N+3.

Source files
------------

// File: rtl/divider_check_mult.sv
// Sequential radix-2 shift-add multiply-add: dividend = quotient * divisor + remainder.
// Optional macro DIVIDER_CHECK_MULT_EARLY_TERM_EN stops once the remaining multiplier bits are zero.
module divider_check_mult #(
    parameter int DIVIDEND_WIDTH = 32,
    parameter int DIVISOR_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] quotient,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    input  logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic [DIVIDEND_WIDTH-1:0] dividend,
    output logic                      overflow,
    output logic                      busy,
    output logic                      done
);

    localparam int ACC_W = DIVIDEND_WIDTH + DIVISOR_WIDTH;
    localparam int CNT_W = $clog2(DIVISOR_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [ACC_W-1:0]           mcand_q, mcand_d;
    logic [DIVISOR_WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0]  dividend_q, dividend_d;
    logic                       overflow_q, overflow_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [ACC_W-1:0]           acc_next;
    logic [DIVISOR_WIDTH-1:0]   mplier_shift;
    logic                       last_iter;

    assign acc_next     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mplier_shift = mplier_q >> 1;

`ifdef DIVIDER_CHECK_MULT_EARLY_TERM_EN
    // No set bits left in the multiplier means every further step would only add zero.
    assign last_iter = (cnt_q == CNT_LAST) || (mplier_shift == '0);
`else
    assign last_iter = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = {{DIVIDEND_WIDTH{1'b0}}, remainder};
                    mcand_d  = {{DIVISOR_WIDTH{1'b0}}, quotient};
                    mplier_d = divisor;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    dividend_d = acc_next[DIVIDEND_WIDTH-1:0];
                    overflow_d = |acc_next[ACC_W-1:DIVIDEND_WIDTH];
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            dividend_q <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dividend = dividend_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_divider_check_mult.sv
// Randomized self-checking bench for divider_check_mult against an arithmetic reference model.
// Honours DIVIDER_CHECK_MULT_EARLY_TERM_EN for the expected latency.
module tb_divider_check_mult;

    localparam int DW = 32;
    localparam int SW = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] quotient;
    logic [SW-1:0] divisor;
    logic [SW-1:0] remainder;
    logic [DW-1:0] dividend;
    logic          overflow;
    logic          busy;
    logic          done;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] hold_div = '0;
    logic          hold_ovf = 1'b0;

    divider_check_mult #(
        .DIVIDEND_WIDTH(DW),
        .DIVISOR_WIDTH (SW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .quotient (quotient),
        .divisor  (divisor),
        .remainder(remainder),
        .dividend (dividend),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Iteration count derived from the divisor value alone.
    function automatic int model_iters(input logic [SW-1:0] d);
        int it;
`ifdef DIVIDER_CHECK_MULT_EARLY_TERM_EN
        it = 1;
        for (int i = 0; i < SW; i++)
            if (d[i]) it = i + 1;
`else
        it = SW;
`endif
        return it;
    endfunction

    task automatic scramble_operands();
        quotient  = $urandom;
        divisor   = SW'($urandom);
        remainder = SW'($urandom);
    endtask

    // Runs one operation; a nonzero inject pulses start with junk operands before edge N+inject.
    task automatic do_op(input logic [DW-1:0] q, input logic [SW-1:0] d,
                         input logic [SW-1:0] r, input int inject);
        logic [63:0]   full;
        logic [DW-1:0] exp_div;
        logic          exp_ovf;
        int            iters;
        full    = 64'(q) * 64'(d) + 64'(r);
        exp_div = full[DW-1:0];
        exp_ovf = |full[63:DW];
        iters   = model_iters(d);
        check("idle_busy", 64'(busy), 64'd0);
        quotient  = q;
        divisor   = d;
        remainder = r;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_operands();
        check("busy_after_start", 64'(busy), 64'd1);
        for (int k = 1; k <= iters + 1; k++) begin
            if (k == inject && k <= iters) begin
                start = 1'b1;
                scramble_operands();
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (k < iters) begin
                check("done_early", 64'(done), 64'd0);
                check("dividend_hold", 64'(dividend), 64'(hold_div));
                check("overflow_hold", 64'(overflow), 64'(hold_ovf));
            end else if (k == iters) begin
                check("done_pulse", 64'(done), 64'd1);
                check("busy_at_done", 64'(busy), 64'd1);
                check("dividend", 64'(dividend), 64'(exp_div));
                check("overflow", 64'(overflow), 64'(exp_ovf));
            end else begin
                check("done_clear", 64'(done), 64'd0);
                check("busy_clear", 64'(busy), 64'd0);
                check("dividend_keep", 64'(dividend), 64'(exp_div));
            end
        end
        hold_div = exp_div;
        hold_ovf = exp_ovf;
        $display("op q=0x%08h d=0x%04h r=0x%04h inject=%0d -> dividend=0x%08h ovf=%0b iters=%0d",
                 q, d, r, inject, dividend, overflow, iters);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        scramble_operands();
        repeat (2) @(posedge clk);
        #1;
        check("rst_dividend", 64'(dividend), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(32'd1000, 16'd7, 16'd5, 0);
        do_op(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 0);
        do_op(32'h0001_0001, 16'hFFFF, 16'h0000, 0);
        do_op(32'h0001_0001, 16'hFFFF, 16'h0001, 0);
        do_op(32'd12345, 16'd678, 16'd9, 5);

        // Reset in the middle of an operation discards it.
        quotient  = 32'd4242;
        divisor   = 16'hFFFF;
        remainder = 16'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_dividend", 64'(dividend), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        for (int k = 0; k < SW + 4; k++) begin
            @(posedge clk); #1;
            check("midrst_no_done", 64'(done), 64'd0);
        end
        hold_div = '0;
        hold_ovf = 1'b0;
        $display("op mid-operation reset -> dividend=0x%08h ovf=%0b", dividend, overflow);

        do_op(32'd333, 16'd300, 16'd100, 0);
        do_op(32'hDEAD_BEEF, 16'h0000, 16'd9, 0);
        do_op(32'd77, 16'h0005, 16'd2, 0);
        do_op(32'd5, 16'h0001, 16'd0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] rq;
            logic [SW-1:0] rd;
            logic [SW-1:0] rr;
            rq = $urandom;
            rd = SW'($urandom);
            rr = SW'($urandom);
            if (n % 4 == 1) rd = rd >> $urandom_range(15, 0);
            do_op(rq, rd, rr, int'($urandom_range(20, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
